// File: rtl/adder_pipe_reg.sv
// Pipelined ripple-carry adder/subtractor: one CHUNK-bit slice per stage, carry handed
// forward one stage per enabled edge, with a valid/ready handshake and registered results.
module adder_pipe_reg #(
  parameter int WIDTH  = 32,
  parameter int STAGES = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             ci,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] s,
  output logic             co,
  output logic             ovf
);
  localparam int CHUNK = WIDTH / STAGES;

  logic             en;
  logic             accept;
  logic [WIDTH-1:0] b_eff;
  logic             c_eff;

  // The whole pipe advances together; it only freezes when a result is waiting unread.
  assign en       = out_ready | ~out_valid;
  assign in_ready = rst_n & en;
  assign accept   = in_valid & in_ready;
  assign b_eff    = b ^ {WIDTH{sub}};
  assign c_eff    = ci ^ sub;

  for (genvar k = 0; k < STAGES; k++) begin : stg
    localparam int REM_W = WIDTH - (k + 1) * CHUNK;

    logic [CHUNK-1:0]         a_c;
    logic [CHUNK-1:0]         b_c;
    logic                     cy_c;
    logic                     vld_c;
    logic [CHUNK:0]           add_c;
    logic [(k+1)*CHUNK-1:0]   sum_c;
    logic                     vld_p;
    logic                     cy_p;
    logic [(k+1)*CHUNK-1:0]   sum_p;

    assign add_c = {1'b0, a_c} + {1'b0, b_c} + {{CHUNK{1'b0}}, cy_c};

    if (k == 0) begin : src
      assign a_c   = a[CHUNK-1:0];
      assign b_c   = b_eff[CHUNK-1:0];
      assign cy_c  = c_eff;
      assign vld_c = accept;
      assign sum_c = add_c[CHUNK-1:0];
    end else begin : src
      assign a_c   = stg[k-1].skw.a_p[CHUNK-1:0];
      assign b_c   = stg[k-1].skw.b_p[CHUNK-1:0];
      assign cy_c  = stg[k-1].cy_p;
      assign vld_c = stg[k-1].vld_p;
      assign sum_c = {add_c[CHUNK-1:0], stg[k-1].sum_p};
    end

    // ---- stage k boundary: chunk sum, chunk carry and valid ----
    always_ff @(posedge clk) begin
      if (!rst_n) begin
        vld_p <= 1'b0;
        cy_p  <= 1'b0;
        sum_p <= '0;
      end else if (en) begin
        vld_p <= vld_c;
        cy_p  <= add_c[CHUNK];
        sum_p <= sum_c;
      end
    end

    // Operand bits not yet consumed ride along so each later stage sees its own chunk.
    if (REM_W > 0) begin : skw
      logic [REM_W-1:0] a_n;
      logic [REM_W-1:0] b_n;
      logic [REM_W-1:0] a_p;
      logic [REM_W-1:0] b_p;

      if (k == 0) begin : fwd
        assign a_n = a[WIDTH-1:CHUNK];
        assign b_n = b_eff[WIDTH-1:CHUNK];
      end else begin : fwd
        assign a_n = stg[k-1].skw.a_p[REM_W+CHUNK-1:CHUNK];
        assign b_n = stg[k-1].skw.b_p[REM_W+CHUNK-1:CHUNK];
      end

      always_ff @(posedge clk) begin
        if (!rst_n) begin
          a_p <= '0;
          b_p <= '0;
        end else if (en) begin
          a_p <= a_n;
          b_p <= b_n;
        end
      end
    end

    // Carry into the MSB is recovered as a^b^sum at that bit; overflow is it XOR carry-out.
    if (k == STAGES - 1) begin : fin
      logic ovf_c;
      logic ovf_p;

      assign ovf_c = a_c[CHUNK-1] ^ b_c[CHUNK-1] ^ add_c[CHUNK-1] ^ add_c[CHUNK];

      always_ff @(posedge clk) begin
        if (!rst_n) begin
          ovf_p <= 1'b0;
        end else if (en) begin
          ovf_p <= ovf_c;
        end
      end
    end
  end

  assign out_valid = stg[STAGES-1].vld_p;
  assign s         = stg[STAGES-1].sum_p;
  assign co        = stg[STAGES-1].cy_p;
  assign ovf       = stg[STAGES-1].fin.ovf_p;

endmodule

// File: tb/tb_adder_pipe_reg.sv
// Bench for adder_pipe_reg: three depths (4, 1, 32 stages) share one stimulus stream,
// each with its own expected-result queue and enabled-edge latency check.
module tb_adder_pipe_reg;
  localparam int W = 32;
  localparam int ND = 3;
  localparam int ST [ND] = '{4, 1, 32};

  logic         clk = 1'b0;
  logic         rst_n;
  logic         in_valid;
  logic         out_ready;
  logic [W-1:0] a, b;
  logic         ci, sub;

  logic         ir  [ND];
  logic         ov  [ND];
  logic [W-1:0] sv  [ND];
  logic         cov [ND];
  logic         ofv [ND];

  // Expected outcome of whatever op is currently on the inputs.
  logic [W-1:0] x_s;
  logic         x_co, x_ovf;

  typedef struct {
    logic [W-1:0] s;
    logic         co;
    logic         ovf;
    int unsigned  tag;
  } exp_t;

  typedef struct {
    logic [W-1:0] a, b;
    logic         ci, sub;
    logic [W-1:0] s;
    logic         co, ovf;
  } vec_t;

  exp_t        sbq [ND][$];
  exp_t        mon_e;
  int unsigned en_cnt [ND];
  int          n_cmp = 0;
  int          n_bad = 0;

  always #5 clk = ~clk;

  adder_pipe_reg #(.WIDTH(W), .STAGES(4)) dut0 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(ir[0]),
    .a(a), .b(b), .ci(ci), .sub(sub), .out_valid(ov[0]), .out_ready(out_ready),
    .s(sv[0]), .co(cov[0]), .ovf(ofv[0]));

  adder_pipe_reg #(.WIDTH(W), .STAGES(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(ir[1]),
    .a(a), .b(b), .ci(ci), .sub(sub), .out_valid(ov[1]), .out_ready(out_ready),
    .s(sv[1]), .co(cov[1]), .ovf(ofv[1]));

  adder_pipe_reg #(.WIDTH(W), .STAGES(32)) dut2 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(ir[2]),
    .a(a), .b(b), .ci(ci), .sub(sub), .out_valid(ov[2]), .out_ready(out_ready),
    .s(sv[2]), .co(cov[2]), .ovf(ofv[2]));

  // Inputs change just after posedge, so at negedge we know what the next edge will do.
  always @(negedge clk) begin
    for (int i = 0; i < ND; i++) begin
      if (!rst_n) begin
        sbq[i].delete();
      end else begin
        if (ov[i] && out_ready) begin
          n_cmp++;
          if (sbq[i].size() == 0) begin
            n_bad++;
            $display("FAIL unexpected_out dut%0d: got s=%h co=%b ovf=%b, required no output", i, sv[i], cov[i], ofv[i]);
          end else begin
            mon_e = sbq[i].pop_front();
            if ({sv[i], cov[i], ofv[i]} !== {mon_e.s, mon_e.co, mon_e.ovf}) begin
              n_bad++;
              $display("FAIL result dut%0d: got s=%h co=%b ovf=%b, required s=%h co=%b ovf=%b",
                       i, sv[i], cov[i], ofv[i], mon_e.s, mon_e.co, mon_e.ovf);
            end
            n_cmp++;
            if (en_cnt[i] - mon_e.tag != ST[i]) begin
              n_bad++;
              $display("FAIL latency dut%0d: got %0d enabled edges, required %0d", i, en_cnt[i] - mon_e.tag, ST[i]);
            end
          end
        end
        if (in_valid && ir[i]) begin
          mon_e.s   = x_s;
          mon_e.co  = x_co;
          mon_e.ovf = x_ovf;
          mon_e.tag = en_cnt[i];
          sbq[i].push_back(mon_e);
        end
        if (out_ready || !ov[i]) en_cnt[i]++;
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got %h, required %h", nm, act, req);
    end
  endtask

  task automatic set_op(input logic [W-1:0] ta, input logic [W-1:0] tb, input logic tci, input logic tsub,
                        input logic [W-1:0] es, input logic eco, input logic eovf);
    in_valid = 1'b1;
    a = ta; b = tb; ci = tci; sub = tsub;
    x_s = es; x_co = eco; x_ovf = eovf;
  endtask

  task automatic set_rand();
    logic [W-1:0] ra, rb, rbe;
    logic [W:0]   t;
    logic         rci, rsub, eovf;
    ra   = $urandom;
    rb   = $urandom;
    rci  = 1'($urandom_range(0, 1));
    rsub = 1'($urandom_range(0, 1));
    if ($urandom_range(0, 3) == 0) ra = 32'h7FFF_FFFF;
    rbe  = rsub ? ~rb : rb;
    t    = {1'b0, ra} + {1'b0, rbe} + {{W{1'b0}}, rci ^ rsub};
    eovf = (ra[W-1] == rbe[W-1]) && (t[W-1] != ra[W-1]);
    set_op(ra, rb, rci, rsub, t[W-1:0], t[W], eovf);
  endtask

  task automatic drain();
    in_valid  = 1'b0;
    out_ready = 1'b1;
    for (int k = 0; k < 100 && (sbq[0].size() + sbq[1].size() + sbq[2].size()) != 0; k++) step();
    for (int i = 0; i < ND; i++) begin
      n_cmp++;
      if (sbq[i].size() != 0) begin
        n_bad++;
        $display("FAIL drain dut%0d: got %0d results outstanding, required 0", i, sbq[i].size());
      end
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t         vt [10];
    logic [W+1:0] hold;

    vt[0] = '{32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 32'h0000_0000, 1'b1, 1'b0};
    vt[1] = '{32'h0000_0005, 32'h0000_0007, 1'b0, 1'b1, 32'hFFFF_FFFE, 1'b0, 1'b0};
    vt[2] = '{32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 32'h8000_0000, 1'b0, 1'b1};
    vt[3] = '{32'h8000_0000, 32'h0000_0001, 1'b0, 1'b1, 32'h7FFF_FFFF, 1'b1, 1'b1};
    vt[4] = '{32'h0000_000A, 32'h0000_0003, 1'b1, 1'b1, 32'h0000_0006, 1'b1, 1'b0};
    vt[5] = '{32'h0000_FFFF, 32'h0000_0001, 1'b1, 1'b0, 32'h0001_0001, 1'b0, 1'b0};
    vt[6] = '{32'h8000_0000, 32'h8000_0000, 1'b0, 1'b0, 32'h0000_0000, 1'b1, 1'b1};
    vt[7] = '{32'h0000_0000, 32'h0000_0000, 1'b0, 1'b1, 32'h0000_0000, 1'b1, 1'b0};
    vt[8] = '{32'h1234_5678, 32'h0FED_CBA9, 1'b0, 1'b0, 32'h2222_2221, 1'b0, 1'b0};
    vt[9] = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 1'b1, 32'hFFFF_FFFF, 1'b0, 1'b0};

    for (int i = 0; i < ND; i++) en_cnt[i] = 0;
    rst_n = 1'b0; out_ready = 1'b1;
    set_op(32'hDEAD_BEEF, 32'h1, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0);

    // Reset held over two edges with in_valid asserted.
    step(); step();
    @(negedge clk);
    for (int i = 0; i < ND; i++) begin
      chk($sformatf("rst_out_valid_dut%0d", i), 64'(ov[i]), 64'd0);
      chk($sformatf("rst_s_dut%0d", i), 64'(sv[i]), 64'd0);
      chk($sformatf("rst_co_ovf_dut%0d", i), 64'({cov[i], ofv[i]}), 64'd0);
      chk($sformatf("rst_in_ready_dut%0d", i), 64'(ir[i]), 64'd0);
    end
    step();
    rst_n = 1'b1; in_valid = 1'b0;
    @(negedge clk);
    for (int i = 0; i < ND; i++) chk($sformatf("post_rst_in_ready_dut%0d", i), 64'(ir[i]), 64'd1);
    step();

    // Directed vectors, with an occasional bubble between them.
    for (int i = 0; i < 10; i++) begin
      set_op(vt[i].a, vt[i].b, vt[i].ci, vt[i].sub, vt[i].s, vt[i].co, vt[i].ovf);
      step();
      if (i % 4 == 3) begin
        in_valid = 1'b0;
        step();
      end
    end
    drain();

    // Eight back-to-back random operations.
    for (int i = 0; i < 8; i++) begin
      set_rand();
      step();
    end
    drain();

    // Backpressure while the 4-stage instance presents a result.
    for (int i = 0; i < 6; i++) begin
      set_rand();
      step();
    end
    out_ready = 1'b0;
    set_rand();
    @(negedge clk);
    hold = {sv[0], cov[0], ofv[0]};
    chk("stall_out_valid", 64'(ov[0]), 64'd1);
    chk("stall_in_ready", 64'(ir[0]), 64'd0);
    for (int i = 0; i < 2; i++) begin
      step();
      set_rand();
      @(negedge clk);
      chk($sformatf("stall_hold_%0d", i), 64'({sv[0], cov[0], ofv[0]}), 64'(hold));
      chk($sformatf("stall_in_ready_%0d", i), 64'(ir[0]), 64'd0);
    end
    step();
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      set_rand();
      step();
    end
    drain();

    // Reset with three operations in flight, then one fresh op after idle cycles.
    for (int i = 0; i < 3; i++) begin
      set_rand();
      step();
    end
    rst_n = 1'b0; in_valid = 1'b0;
    step(); step();
    rst_n = 1'b1;
    step(); step(); step();
    set_rand();
    step();
    drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
